// File: rtl/core_dbg_hub_pkg.sv
// Shared types and constants for the multi-hart debug hub.
// Holds the abstract-register FSM states, cmderr codes and regno bounds.
package core_dbg_pkg;

  typedef enum logic [2:0] {
    AR_IDLE  = 3'd0,
    AR_CHECK = 3'd1,
    AR_ISSUE = 3'd2,
    AR_WAIT  = 3'd3,
    AR_DONE  = 3'd4
  } ar_state_e;

  localparam logic [2:0] CMDERR_NONE       = 3'd0;
  localparam logic [2:0] CMDERR_BUSY       = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0] CMDERR_TIMEOUT    = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

  localparam logic [15:0] CSR_MAX  = 16'h0FFF;
  localparam logic [15:0] GPR_BASE = 16'h1000;
  localparam logic [15:0] GPR_MAX  = 16'h101F;

  // CSRs and GPRs form one contiguous window starting at regno 0.
  function automatic logic regno_supported(input logic [15:0] ad);
    return (ad <= GPR_MAX);
  endfunction

endpackage

// File: rtl/core_dbg_hub_if.sv
// Debug-module side bus of the hub: hart selection, run control and
// abstract-register command/status.
interface core_dbg_hub_if #(
  parameter int HARTSEL_W = 4
);

  logic [HARTSEL_W-1:0] dm_hartsel;
  logic                 dm_haltreq;
  logic                 dm_resumereq;
  logic                 dm_ar_en;
  logic                 dm_ar_wr;
  logic [15:0]          dm_ar_ad;
  logic [31:0]          dm_ar_do;
  logic                 dm_ar_err_clr;
  logic [31:0]          dm_ar_di;
  logic                 dm_ar_done;
  logic                 dm_ar_busy;
  logic [2:0]           dm_ar_err;
  logic                 dm_anyhalted;
  logic                 dm_allhalted;
  logic                 dm_anyrunning;
  logic                 dm_allrunning;
  logic                 dm_anyresumeack;
  logic                 dm_allresumeack;

  modport master (
    output dm_hartsel, dm_haltreq, dm_resumereq,
    output dm_ar_en, dm_ar_wr, dm_ar_ad, dm_ar_do, dm_ar_err_clr,
    input  dm_ar_di, dm_ar_done, dm_ar_busy, dm_ar_err,
    input  dm_anyhalted, dm_allhalted, dm_anyrunning, dm_allrunning,
    input  dm_anyresumeack, dm_allresumeack
  );

  modport slave (
    input  dm_hartsel, dm_haltreq, dm_resumereq,
    input  dm_ar_en, dm_ar_wr, dm_ar_ad, dm_ar_do, dm_ar_err_clr,
    output dm_ar_di, dm_ar_done, dm_ar_busy, dm_ar_err,
    output dm_anyhalted, dm_allhalted, dm_anyrunning, dm_allrunning,
    output dm_anyresumeack, dm_allresumeack
  );

endinterface

// File: rtl/core_dbg_hub_ar_seq.sv
// Abstract-register command sequencer: latches a DM command, validates it,
// strobes the selected hart and reports done/busy/cmderr with a timeout.
module core_dbg_ar_seq
  import core_dbg_pkg::*;
#(
  parameter int NUM_HARTS  = 4,
  parameter int HARTSEL_W  = 4,
  parameter int AR_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [HARTSEL_W-1:0]      hartsel,
  input  logic                      ar_en,
  input  logic                      ar_wr,
  input  logic [15:0]               ar_ad,
  input  logic [31:0]               ar_do,
  input  logic                      err_clr,
  output logic [31:0]               ar_di,
  output logic                      ar_done,
  output logic                      ar_busy,
  output logic [2:0]                ar_err,
  input  logic [NUM_HARTS-1:0]      hart_halted,
  input  logic [NUM_HARTS-1:0]      hart_ar_done,
  input  logic [32*NUM_HARTS-1:0]   hart_ar_di,
  output logic [NUM_HARTS-1:0]      hart_ar_en,
  output logic                      hart_ar_wr,
  output logic [15:0]               hart_ar_ad,
  output logic [31:0]               hart_ar_do
);

  localparam int CNT_W = (AR_TIMEOUT > 2) ? $clog2(AR_TIMEOUT) : 1;

  ar_state_e             state_r;
  ar_state_e             state_n_s;
  logic [HARTSEL_W-1:0]  sel_r;
  logic                  wr_r;
  logic [15:0]           ad_r;
  logic [31:0]           do_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_n_s;
  logic [2:0]            err_r;
  logic [2:0]            err_n_s;
  logic [2:0]            fsm_err_s;
  logic                  fsm_err_set_s;
  logic                  latch_s;
  logic                  capture_s;
  logic [31:0]           di_r;
  logic                  done_r;
  logic                  busy_r;
  logic [NUM_HARTS-1:0]  hart_en_r;
  logic [NUM_HARTS-1:0]  sel_oh_s;
  logic [31:0]           sel_di_s;
  logic                  sel_exists_s;
  logic                  sel_halted_s;
  logic                  sel_done_s;

  // Decode the latched hart index; an out-of-range index yields an all-zero one-hot.
  always_comb begin
    sel_oh_s = '0;
    sel_di_s = 32'd0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      sel_oh_s[i] = (sel_r == HARTSEL_W'(i));
      sel_di_s    = sel_di_s | (hart_ar_di[32*i +: 32] & {32{sel_oh_s[i]}});
    end
  end

  assign sel_exists_s = |sel_oh_s;
  assign sel_halted_s = |(sel_oh_s & hart_halted);
  assign sel_done_s   = |(sel_oh_s & hart_ar_done);

  // Next-state and per-state actions of the command FSM.
  always_comb begin
    state_n_s     = state_r;
    cnt_n_s       = cnt_r;
    fsm_err_s     = CMDERR_NONE;
    fsm_err_set_s = 1'b0;
    latch_s       = 1'b0;
    capture_s     = 1'b0;
    case (state_r)
      AR_IDLE: begin
        if (ar_en && (err_r == CMDERR_NONE)) begin
          state_n_s = AR_CHECK;
          latch_s   = 1'b1;
        end else begin
          state_n_s = AR_IDLE;
        end
      end
      AR_CHECK: begin
        if (!sel_exists_s) begin
          state_n_s     = AR_DONE;
          fsm_err_s     = CMDERR_HALTRESUME;
          fsm_err_set_s = 1'b1;
        end else if (!sel_halted_s) begin
          state_n_s     = AR_DONE;
          fsm_err_s     = CMDERR_HALTRESUME;
          fsm_err_set_s = 1'b1;
        end else if (!regno_supported(ad_r)) begin
          state_n_s     = AR_DONE;
          fsm_err_s     = CMDERR_NOTSUP;
          fsm_err_set_s = 1'b1;
        end else begin
          state_n_s = AR_ISSUE;
        end
      end
      AR_ISSUE: begin
        if (sel_done_s) begin
          state_n_s = AR_DONE;
          capture_s = ~wr_r;
        end else begin
          state_n_s = AR_WAIT;
          cnt_n_s   = CNT_W'(1);
        end
      end
      AR_WAIT: begin
        if (sel_done_s) begin
          state_n_s = AR_DONE;
          capture_s = ~wr_r;
        end else if (cnt_r == CNT_W'(AR_TIMEOUT - 1)) begin
          state_n_s     = AR_DONE;
          fsm_err_s     = CMDERR_TIMEOUT;
          fsm_err_set_s = 1'b1;
        end else begin
          cnt_n_s = cnt_r + CNT_W'(1);
        end
      end
      AR_DONE: begin
        state_n_s = AR_IDLE;
      end
      default: begin
        state_n_s = AR_IDLE;
      end
    endcase
  end

  // Sticky cmderr: a freshly detected error overrides a simultaneous clear.
  always_comb begin
    err_n_s = err_r;
    if (fsm_err_set_s) begin
      err_n_s = fsm_err_s;
    end else if (ar_en && (state_r != AR_IDLE) && (err_r == CMDERR_NONE)) begin
      err_n_s = CMDERR_BUSY;
    end else if (err_clr) begin
      err_n_s = CMDERR_NONE;
    end else begin
      err_n_s = err_r;
    end
  end

  // State, command latch and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= AR_IDLE;
      sel_r     <= '0;
      wr_r      <= 1'b0;
      ad_r      <= 16'd0;
      do_r      <= 32'd0;
      cnt_r     <= '0;
      err_r     <= CMDERR_NONE;
      di_r      <= 32'd0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      hart_en_r <= '0;
    end else begin
      state_r   <= state_n_s;
      cnt_r     <= cnt_n_s;
      err_r     <= err_n_s;
      done_r    <= (state_n_s == AR_DONE);
      busy_r    <= (state_n_s != AR_IDLE);
      hart_en_r <= (state_n_s == AR_ISSUE) ? sel_oh_s : '0;
      if (latch_s) begin
        sel_r <= hartsel;
        wr_r  <= ar_wr;
        ad_r  <= ar_ad;
        do_r  <= ar_do;
      end else if (state_n_s == AR_IDLE) begin
        wr_r  <= 1'b0;
        ad_r  <= 16'd0;
        do_r  <= 32'd0;
      end
      if (capture_s) begin
        di_r <= sel_di_s;
      end
    end
  end

  assign ar_di      = di_r;
  assign ar_done    = done_r;
  assign ar_busy    = busy_r;
  assign ar_err     = err_r;
  assign hart_ar_en = hart_en_r;
  assign hart_ar_wr = wr_r;
  assign hart_ar_ad = ad_r;
  assign hart_ar_do = do_r;

endmodule

// File: rtl/core_dbg_hub.sv
// Multi-hart debug hub: routes halt/resume to the selected hart, summarises
// per-hart run state and delegates abstract register access to core_dbg_ar_seq.
module core_dbg_hub
  import core_dbg_pkg::*;
#(
  parameter int NUM_HARTS  = 4,
  parameter int HARTSEL_W  = 4,
  parameter int AR_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  core_dbg_hub_if.slave            dm,
  output logic [NUM_HARTS-1:0]     hart_haltreq,
  output logic [NUM_HARTS-1:0]     hart_resumereq,
  input  logic [NUM_HARTS-1:0]     hart_halted,
  input  logic [NUM_HARTS-1:0]     hart_running,
  input  logic [NUM_HARTS-1:0]     hart_resumeack,
  output logic [NUM_HARTS-1:0]     hart_ar_en,
  output logic                     hart_ar_wr,
  output logic [15:0]              hart_ar_ad,
  output logic [31:0]              hart_ar_do,
  input  logic [32*NUM_HARTS-1:0]  hart_ar_di,
  input  logic [NUM_HARTS-1:0]     hart_ar_done
);

  logic [NUM_HARTS-1:0] dm_sel_oh_s;
  logic [NUM_HARTS-1:0] resume_issue_s;
  logic [NUM_HARTS-1:0] haltreq_r;
  logic [NUM_HARTS-1:0] resumereq_r;
  logic [NUM_HARTS-1:0] resumeack_r;

  // Live decode of the DM hart select; nonexistent harts decode to zero.
  always_comb begin
    dm_sel_oh_s = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      dm_sel_oh_s[i] = (dm.dm_hartsel == HARTSEL_W'(i));
    end
  end

  assign resume_issue_s = dm.dm_resumereq ? (dm_sel_oh_s & hart_halted) : '0;

  // Halt/resume routing and sticky resumeack; a new resume clears stale acks.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      haltreq_r   <= '0;
      resumereq_r <= '0;
      resumeack_r <= '0;
    end else begin
      haltreq_r   <= dm.dm_haltreq ? dm_sel_oh_s : '0;
      resumereq_r <= resume_issue_s;
      resumeack_r <= (resumeack_r | hart_resumeack) & ~resume_issue_s;
    end
  end

  assign hart_haltreq   = haltreq_r;
  assign hart_resumereq = resumereq_r;

  assign dm.dm_anyhalted    = |hart_halted;
  assign dm.dm_allhalted    = &hart_halted;
  assign dm.dm_anyrunning   = |hart_running;
  assign dm.dm_allrunning   = &hart_running;
  assign dm.dm_anyresumeack = |resumeack_r;
  assign dm.dm_allresumeack = &resumeack_r;

  core_dbg_ar_seq #(
    .NUM_HARTS  (NUM_HARTS),
    .HARTSEL_W  (HARTSEL_W),
    .AR_TIMEOUT (AR_TIMEOUT)
  ) u_ar_seq (
    .clk          (clk),
    .reset_n      (reset_n),
    .hartsel      (dm.dm_hartsel),
    .ar_en        (dm.dm_ar_en),
    .ar_wr        (dm.dm_ar_wr),
    .ar_ad        (dm.dm_ar_ad),
    .ar_do        (dm.dm_ar_do),
    .err_clr      (dm.dm_ar_err_clr),
    .ar_di        (dm.dm_ar_di),
    .ar_done      (dm.dm_ar_done),
    .ar_busy      (dm.dm_ar_busy),
    .ar_err       (dm.dm_ar_err),
    .hart_halted  (hart_halted),
    .hart_ar_done (hart_ar_done),
    .hart_ar_di   (hart_ar_di),
    .hart_ar_en   (hart_ar_en),
    .hart_ar_wr   (hart_ar_wr),
    .hart_ar_ad   (hart_ar_ad),
    .hart_ar_do   (hart_ar_do)
  );

endmodule
